fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Control block for the synchronous FIFO.
- Sequences the write and read address counters and gates memory write/read strobes.
- Tracks occupancy through a 3-state FSM (EMPTY / PARTIAL / FULL) and drives full/empty/count status to the producer and consumer.
- Sits between the requesters and the FIFO RAM; the RAM reads its addresses straight from w_ptr/r_ptr.

Parameters:
- MEMORY_DEPTH, 4, number of FIFO entries; any value ≥2, not restricted to powers of two.
- FIFO_ADDRESS_SIZE, 2, address bits; pointer and count ports are FIFO_ADDRESS_SIZE+1 wide; requires MEMORY_DEPTH ≤ 2^FIFO_ADDRESS_SIZE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  1  producer write request.
- rd_req  in  1  consumer read request.
- w_ptr  out  FIFO_ADDRESS_SIZE+1  RAM write address, 0..MEMORY_DEPTH-1.
- r_ptr  out  FIFO_ADDRESS_SIZE+1  RAM read address, 0..MEMORY_DEPTH-1.
- cw_en  out  1  write accepted this cycle; drives RAM write enable.
- cr_en  out  1  read accepted this cycle; drives RAM read enable.
- full  out  1  FSM in FULL.
- empty  out  1  FSM in EMPTY.
- count  out  FIFO_ADDRESS_SIZE+1  occupancy, 0..MEMORY_DEPTH.
- overflow  out  1  sticky error flag (see Optional Feature).
- underflow  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - w_ptr=0, r_ptr=0, count=0, state=EMPTY.
  - empty=1, full=0, overflow=0, underflow=0.
  - cw_en=0 and cr_en=0 while rst_n=0.
- Acceptance (combinational, from registered state only; no dependence on same-cycle acceptance of the other side):
  - cw_en = wr_req & !full
  - cr_en = rd_req & !empty
- Pointer update, registered, 1-cycle latency:
  - On cw_en, w_ptr increments; when w_ptr == MEMORY_DEPTH-1 it wraps to 0 instead.
  - r_ptr follows the same rule on cr_en.
  - An unaccepted request leaves its pointer unchanged.
- Count update:
  - +1 on cw_en only; -1 on cr_en only; unchanged when both or neither.
  - Never leaves the range 0..MEMORY_DEPTH.
- FSM, state registered; full/empty decoded from state (registered outputs):
  - EMPTY: cw_en → PARTIAL, or → FULL if MEMORY_DEPTH==1 (disallowed by parameter rule). rd_req is ignored.
  - PARTIAL:
    - cw_en & !cr_en & count==MEMORY_DEPTH-1 → FULL.
    - cr_en & !cw_en & count==1 → EMPTY.
    - Otherwise stay.
  - FULL: cr_en → PARTIAL. wr_req is ignored.
- Simultaneous wr_req and rd_req:
  - In PARTIAL: both accepted, both pointers advance, count and state unchanged.
  - In EMPTY: write only; no fall-through.
  - In FULL: read only; no pass-through.
- Wrap-around: the pointers' equality is never used for status. Status derives from the FSM/count, so full and empty are unambiguous when w_ptr==r_ptr.
- Reset mid-operation: all state returns immediately to reset values. RAM contents are not cleared but are treated as invalid.

Optional Feature:
- Macro: FIFO_CTRL_ERR_FLAGS_EN.
- Defined:
  - overflow sets on the cycle after wr_req while full.
  - underflow sets on the cycle after rd_req while empty.
  - Both stay set until rst_n asserts.
- Undefined: overflow and underflow are tied to 0 and no flag registers exist. The port list is identical in both builds.

Decomposition:
- Shared package/header fifo_ctrl_pkg holds:
  - FSM state encodings: EMPTY=2'b00, PARTIAL=2'b01, FULL=2'b10.
  - Default depth and address-width localparams, so the RAM and controller agree.
- One sub-module: wrap_counter (params SIZE, MAX).
  - Enable-gated register with async active-low clear.
  - Next value = (q==MAX) ? 0 : q+1.
  - Exposes an at_max output.
  - Instantiated twice, once for w_ptr and once for r_ptr.

Test Plan:
- Reset check: assert rst_n=0 mid-traffic → all outputs return to reset values immediately; empty=1, count=0, w_ptr=r_ptr=0.
- Fill (DEPTH=4): 4 back-to-back writes from empty → w_ptr 1,2,3,0; count 1..4; full=1 after the 4th; 5th write gives cw_en=0 and w_ptr stays 0.
- Drain: 4 reads from full → r_ptr 1,2,3,0; empty=1 after the 4th; 5th read gives cr_en=0.
- Simultaneous requests:
  - count=2, wr+rd for 6 cycles → count stays 2, both pointers wrap correctly, full=empty=0 throughout.
  - From empty, wr+rd → only cw_en.
  - From full, wr+rd → only cr_en.
- Non-power-of-two (MEMORY_DEPTH=3, FIFO_ADDRESS_SIZE=2): 7 write/read pairs → pointers cycle 0,1,2,0 and never reach 3.
- Error flags with macro defined: write while full → overflow=1 next cycle and stays 1 until reset. Same check with the macro undefined → overflow stays 0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO controller and its RAM:
// FSM state encodings and the default depth / address width.
package fifo_ctrl_pkg;

    localparam logic [1:0] ST_EMPTY   = 2'b00;
    localparam logic [1:0] ST_PARTIAL = 2'b01;
    localparam logic [1:0] ST_FULL    = 2'b10;

    localparam int DEFAULT_DEPTH     = 4;
    localparam int DEFAULT_ADDR_SIZE = 2;

endpackage : fifo_ctrl_pkg

// File: rtl/wrap_counter.sv
// Enable-gated modulo counter: counts 0..MAX and wraps to 0, so depths that
// are not powers of two are handled without address holes.
module wrap_counter #(
    parameter int SIZE = 3,
    parameter int MAX  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [SIZE-1:0] q,
    output logic            at_max
);

    localparam logic [SIZE-1:0] MAX_V = SIZE'(MAX);
    localparam logic [SIZE-1:0] ONE_V = SIZE'(1);

    assign at_max = (q == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= at_max ? '0 : q + ONE_V;
        end
    end

endmodule : wrap_counter

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO control: pointer sequencing, strobe gating and an
// EMPTY/PARTIAL/FULL occupancy FSM. Sticky overflow/underflow flags are built
// only when FIFO_CTRL_ERR_FLAGS_EN is defined; otherwise they are tied low.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int MEMORY_DEPTH      = DEFAULT_DEPTH,
    parameter int FIFO_ADDRESS_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_req,
    input  logic                       rd_req,
    output logic [FIFO_ADDRESS_SIZE:0] w_ptr,
    output logic [FIFO_ADDRESS_SIZE:0] r_ptr,
    output logic                       cw_en,
    output logic                       cr_en,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_ADDRESS_SIZE:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = FIFO_ADDRESS_SIZE + 1;

    localparam logic [PW-1:0] DEPTH_V  = PW'(MEMORY_DEPTH);
    localparam logic [PW-1:0] DEPTH_M1 = PW'(MEMORY_DEPTH - 1);
    localparam logic [PW-1:0] ONE_V    = PW'(1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] count_q;
    logic [PW-1:0] count_nxt;
    logic [1:0]    at_max_unused;

    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
        return (v == DEPTH_V) ? v : v + ONE_V;
    endfunction

    function automatic logic [PW-1:0] sat_dec(input logic [PW-1:0] v);
        return (v == '0) ? v : v - ONE_V;
    endfunction

    // Status comes only from the FSM, never from pointer equality.
    assign full  = (state == ST_FULL);
    assign empty = (state == ST_EMPTY);
    assign count = count_q;

    // rst_n gate keeps the strobes quiet while reset is held.
    assign cw_en = rst_n & wr_req & ~full;
    assign cr_en = rst_n & rd_req & ~empty;

    wrap_counter #(
        .SIZE (PW),
        .MAX  (MEMORY_DEPTH - 1)
    ) u_wr_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (cw_en),
        .q      (w_ptr),
        .at_max (at_max_unused[0])
    );

    wrap_counter #(
        .SIZE (PW),
        .MAX  (MEMORY_DEPTH - 1)
    ) u_rd_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (cr_en),
        .q      (r_ptr),
        .at_max (at_max_unused[1])
    );

    always_comb begin
        count_nxt = count_q;
        if (cw_en && !cr_en) begin
            count_nxt = sat_inc(count_q);
        end else if (cr_en && !cw_en) begin
            count_nxt = sat_dec(count_q);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (cw_en) begin
                    state_nxt = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (cw_en && !cr_en && count_q == DEPTH_M1) begin
                    state_nxt = ST_FULL;
                end else if (cr_en && !cw_en && count_q == ONE_V) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (cr_en) begin
                    state_nxt = ST_PARTIAL;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            count_q <= count_nxt;
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky until the next reset so a late-reading host still sees the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_req && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Directed, table-driven bench for fifo_ctrl (depth 4) plus hand sequences for
// a depth-3 instance and asynchronous reset in the middle of traffic.
module tb_fifo_ctrl;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_req, rd_req;
    logic [2:0] w_ptr, r_ptr, count;
    logic       cw_en, cr_en, full, empty, overflow, underflow;

    logic       wr3, rd3;
    logic [2:0] w_ptr3, r_ptr3, count3;
    logic       cw_en3, cr_en3, full3, empty3, overflow3, underflow3;

    int n_vec = 0;
    int n_bad = 0;

    fifo_ctrl #(.MEMORY_DEPTH(4), .FIFO_ADDRESS_SIZE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .w_ptr(w_ptr), .r_ptr(r_ptr), .cw_en(cw_en), .cr_en(cr_en),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_ctrl #(.MEMORY_DEPTH(3), .FIFO_ADDRESS_SIZE(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr3), .rd_req(rd3),
        .w_ptr(w_ptr3), .r_ptr(r_ptr3), .cw_en(cw_en3), .cr_en(cr_en3),
        .full(full3), .empty(empty3), .count(count3),
        .overflow(overflow3), .underflow(underflow3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic wr, rd;
        logic cw, cr;
        int   wp, rp, cnt;
        logic fl, em, ov, uf;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] post_dut();
        return {19'd0, w_ptr, r_ptr, count, full, empty, overflow, underflow};
    endfunction

    function automatic logic [31:0] post_exp(input int wp, input int rp, input int cnt,
                                             input logic fl, input logic em,
                                             input logic ov, input logic uf);
        return {19'd0, 3'(wp), 3'(rp), 3'(cnt), fl, em, ov & ERR, uf & ERR};
    endfunction

    initial begin
        //            wr    rd    cw    cr    wp rp cnt fl    em    ov    uf
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 3, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 0, 2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 1, 2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 2, 2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 3, 2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 0, 2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 1, 2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 2, 2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 4, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset with requests held: strobes must stay low.
        rst_n = 1'b0; wr_req = 1'b1; rd_req = 1'b1; wr3 = 1'b1; rd3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", post_dut(), post_exp(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        check("reset_strobes", {30'd0, cw_en, cr_en}, 32'd0);
        check("reset_state3", {20'd0, w_ptr3, r_ptr3, count3, full3, empty3, cw_en3},
              {20'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0; wr3 = 1'b0; rd3 = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wr_req = vecs[i].wr;
            rd_req = vecs[i].rd;
            #1;
            check($sformatf("v%0d_strobes", i), {30'd0, cw_en, cr_en},
                  {30'd0, vecs[i].cw, vecs[i].cr});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_state", i), post_dut(),
                  post_exp(vecs[i].wp, vecs[i].rp, vecs[i].cnt, vecs[i].fl,
                           vecs[i].em, vecs[i].ov, vecs[i].uf));
        end
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;

        // Depth 3: write/read pairs, pointers must cycle 0,1,2,0.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            wr3 = 1'b1; rd3 = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("d3_wr%0d", i), {23'd0, w_ptr3, r_ptr3, count3},
                  {23'd0, 3'((i + 1) % 3), 3'(i % 3), 3'd1});
            @(negedge clk);
            wr3 = 1'b0; rd3 = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("d3_rd%0d", i), {23'd0, w_ptr3, r_ptr3, count3, empty3},
                  {22'd0, 3'((i + 1) % 3), 3'((i + 1) % 3), 3'd0, 1'b1});
        end
        @(negedge clk);
        wr3 = 1'b0; rd3 = 1'b0;

        // Asynchronous reset in the middle of traffic.
        wr_req = 1'b1; rd_req = 1'b1; wr3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_state", post_dut(), post_exp(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        check("midrst_strobes", {30'd0, cw_en, cr_en}, 32'd0);
        check("midrst_state3", {23'd0, w_ptr3, r_ptr3, count3}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_hold", post_dut(), post_exp(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1; rd_req = 1'b0; wr3 = 1'b0;
        #1;
        check("postrst_strobes", {30'd0, cw_en, cr_en}, {30'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        check("postrst_write", post_dut(), post_exp(1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        wr_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fifo_ctrl
